// File: rtl/fetch_pkg.sv
// Shared fetch definitions: word width, NOP encoding, reset PC,
// and the slot record held in the fetch buffer.
package fetch_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP = 32'h0000_0013;
  localparam word_t RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t instr;
    logic  filled;
  } slot_t;

  function automatic word_t align(input word_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_slot_buffer.sv
// In-order slot buffer: allocate at tail on request, fill the oldest
// unfilled slot on response, pop the head once it is filled.
module fetch_slot_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc,
  input  word_t         alloc_pc,
  input  logic          fill,
  input  word_t         fill_data,
  input  logic          pop,
  output logic          head_filled,
  output word_t         head_pc,
  output word_t         head_instr,
  output logic          full,
  output logic [CW-1:0] unfilled
);
  slot_t         slots [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] fptr;
  logic [CW-1:0] count;
  logic [CW-1:0] unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      fptr  <= '0;
      count <= '0;
      unf   <= '0;
      for (int i = 0; i < DEPTH; i++)
        slots[i] <= '{pc: '0, instr: NOP, filled: 1'b0};
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      fptr  <= '0;
      count <= '0;
      unf   <= '0;
      for (int i = 0; i < DEPTH; i++)
        slots[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        slots[tail] <= '{pc: alloc_pc, instr: NOP, filled: 1'b0};
        tail <= tail + 1'b1;
      end
      if (fill) begin
        slots[fptr].instr  <= fill_data;
        slots[fptr].filled <= 1'b1;
        fptr <= fptr + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      count <= count + CW'(alloc) - CW'(pop);
      unf   <= unf + CW'(alloc) - CW'(fill);
    end
  end

  assign head_filled = (count != '0) && slots[head].filled;
  assign head_pc     = slots[head].pc;
  assign head_instr  = head_filled ? slots[head].instr : NOP;
  assign full        = (count == CW'(DEPTH));
  assign unfilled    = unf;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, request credit, and discard of
// responses that belong to a path abandoned by a redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF,
  parameter int    DEPTH    = 2
) (
  input  logic  clk,
  input  logic  rst,
  output logic  imem_req_valid_o,
  output word_t imem_req_addr_o,
  input  logic  imem_req_ready_i,
  input  logic  imem_rsp_valid_i,
  input  word_t imem_rsp_data_i,
  input  logic  redirect_i,
  input  word_t redirect_pc_i,
  input  logic  stall_d_i,
  output logic  instr_valid_d_o,
  output word_t instr_d_o,
  output word_t pc_d_o,
  output word_t pc_plus4_d_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  word_t         pc_f;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] unfilled;
  logic [CW:0]   inflight;
  logic          full;
  logic          head_filled;
  word_t         head_pc;
  word_t         head_instr;
  logic          hs;
  logic          pop;
  logic          fill;
  logic          credit;
  logic          unexpected;

  assign inflight = {1'b0, drop_cnt} + {1'b0, unfilled};
  assign credit   = inflight < (CW+1)'(DEPTH);

  assign instr_valid_d_o = head_filled & ~redirect_i;
  assign pop             = instr_valid_d_o & ~stall_d_i;

  // A same-cycle pop frees the head slot for the new allocation.
  assign imem_req_valid_o = (~full | pop) & credit
                          & ~redirect_i & ~rst;
  assign imem_req_addr_o  = pc_f;
  assign hs = imem_req_valid_o & imem_req_ready_i;

  assign fill = imem_rsp_valid_i & ~redirect_i
              & (drop_cnt == '0) & (unfilled != '0);
  assign unexpected = imem_rsp_valid_i & ~redirect_i
                    & (drop_cnt == '0) & (unfilled == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f     <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_i) begin
      pc_f     <= align(redirect_pc_i);
      // Everything still in flight belongs to the dead path.
      drop_cnt <= CW'(inflight - (CW+1)'(imem_rsp_valid_i
                  && inflight != '0));
    end else begin
      if (hs)
        pc_f <= pc_f + 32'd4;
      if (imem_rsp_valid_i && drop_cnt != '0)
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_slot_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_i),
    .alloc       (hs),
    .alloc_pc    (pc_f),
    .fill        (fill),
    .fill_data   (imem_rsp_data_i),
    .pop         (pop),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .full        (full),
    .unfilled    (unfilled)
  );

  assign instr_d_o    = head_instr;
  assign pc_d_o       = head_pc;
  assign pc_plus4_d_o = head_pc + 32'd4;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!unexpected)
        else $error("fetch_stage: response with nothing outstanding");
  end
`endif
endmodule
